parallel_serial: RTL

//  Upstream transmit stage for serial_parallel. Accepts one parallel word plus a bit count via a

---
 rtl/parallel_serial_pkg.sv | 22 ++
 rtl/parallel_serial_if.sv | 30 +++
 rtl/parallel_serial_bit_counter.sv | 38 +++
 rtl/parallel_serial.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/parallel_serial_pkg.sv
// Shared definitions for the parallel_serial transmit stage.
// Contents:
//   - default word / length-field widths, also used by the serial_parallel receiver
//   - FSM state encoding (S_IDLE=0, S_START=1, S_DATA=2, S_STOP=3)
//   - idle level of the serial line
package parallel_serial_pkg;

  localparam int PS_PORT_WIDTH    = 14;
  localparam int PS_EXTRACT_LNGTH = 4;
  localparam int PS_STATE_BW      = 2;
  localparam int PS_STOP_CYCLES   = 1;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ps_state_t;

endpackage

// File: rtl/parallel_serial_if.sv
// Load / serial-line bundle for parallel_serial.
//
// Handshake: a load is accepted on the rising clk edge where ld_valid and
// ld_ready are both high. The master holds din/bit_length stable while
// ld_valid is high and ld_ready is low; ld_ready does not depend on ld_valid.
//
// Signals: din, bit_length, ld_valid (master -> slave);
//          ld_ready, dout, en_out, done (slave -> master).
interface parallel_serial_if #(
  parameter int PORT_WIDTH    = 14,
  parameter int EXTRACT_LNGTH = 4
);
  logic [PORT_WIDTH-1:0]    din;
  logic [EXTRACT_LNGTH-1:0] bit_length;
  logic                     ld_valid;
  logic                     ld_ready;
  logic                     dout;
  logic                     en_out;
  logic                     done;

  modport master (
    output din, bit_length, ld_valid,
    input  ld_ready, dout, en_out, done
  );

  modport slave (
    input  din, bit_length, ld_valid,
    output ld_ready, dout, en_out, done
  );
endinterface

// File: rtl/parallel_serial_bit_counter.sv
// ps_bit_counter: loadable up-counter with terminal-count flags.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   load       clear count to 0 and capture limit
//   limit      last count value (terminal count)
//   inc        advance count by one (ignored while load is high)
//   cnt        current count
//   tc         cnt == captured limit
//   tc_next    cnt + 1 == captured limit (next cycle is terminal)
module ps_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] limit,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         tc_next
);
  logic [W-1:0] lim_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      lim_q <= '0;
    end else if (load) begin
      cnt   <= '0;
      lim_q <= limit;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc      = (cnt == lim_q);
  assign tc_next = (W'(cnt + W'(1)) == lim_q);
endmodule

// File: rtl/parallel_serial.sv
// parallel_serial: loads a parallel word and sends it LSB-first as a framed
// serial stream: one low START cycle, N data bits with en_out high, then
// STOP_CYCLES idle-high cycles, done pulsing on the last one.
// Optional feature: define PS_PARITY_EN to append an even-parity bit
// (en_out high) after the data bits.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   bus         parallel_serial_if.slave (din, bit_length, ld_valid in;
//               ld_ready, dout, en_out, done out)
//   state_dbg   current FSM state for observation
module parallel_serial
  import parallel_serial_pkg::*;
#(
  parameter int PORT_WIDTH    = PS_PORT_WIDTH,
  parameter int EXTRACT_LNGTH = PS_EXTRACT_LNGTH,
  parameter int STATE_BW      = PS_STATE_BW,
  parameter int STOP_CYCLES   = PS_STOP_CYCLES
) (
  input  logic                clk,
  input  logic                rstn,
  parallel_serial_if.slave    bus,
  output logic [STATE_BW-1:0] state_dbg
);
  localparam int EL = EXTRACT_LNGTH;
  localparam logic [EL-1:0] PW_L     = EL'(PORT_WIDTH);
  localparam logic [EL-1:0] STOP_LIM = EL'(STOP_CYCLES - 1);
`ifdef PS_PARITY_EN
  localparam logic [EL-1:0] PAR_INC  = EL'(1);
`else
  localparam logic [EL-1:0] PAR_INC  = EL'(0);
`endif

  ps_state_t             state_q;
  logic [PORT_WIDTH-1:0] shreg_q;
  logic [EL-1:0]         n_q;
  logic                  par_q;
  logic                  dout_q, en_q, done_q;

  logic [EL-1:0] d_cnt;       // DATA-phase cycles: N plus optional parity
  logic [EL-1:0] next_idx;
  logic          ctr_load, ctr_inc, ctr_tc, ctr_tc_next;
  logic [EL-1:0] ctr_limit, ctr_cnt;

  assign d_cnt    = n_q + PAR_INC;
  assign next_idx = ctr_cnt + EL'(1);

  // One counter serves both phases: bit index in DATA, cycle index in STOP.
  ps_bit_counter #(.W(EL)) u_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .load    (ctr_load),
    .limit   (ctr_limit),
    .inc     (ctr_inc),
    .cnt     (ctr_cnt),
    .tc      (ctr_tc),
    .tc_next (ctr_tc_next)
  );

  always_comb begin
    ctr_load  = 1'b0;
    ctr_limit = '0;
    ctr_inc   = 1'b0;
    case (state_q)
      S_START: begin
        ctr_load  = 1'b1;
        ctr_limit = (d_cnt != '0) ? d_cnt - EL'(1) : STOP_LIM;
      end
      S_DATA: begin
        if (ctr_tc) begin
          ctr_load  = 1'b1;
          ctr_limit = STOP_LIM;
        end else begin
          ctr_inc = 1'b1;
        end
      end
      S_STOP:  ctr_inc = !ctr_tc;
      default: ;
    endcase
  end

  // Outputs are registered: each transition drives the values of the
  // state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      n_q     <= '0;
      par_q   <= 1'b0;
      dout_q  <= LINE_IDLE;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dout_q <= LINE_IDLE;
          en_q   <= 1'b0;
          done_q <= 1'b0;
          if (bus.ld_valid) begin
            shreg_q <= bus.din;
            n_q     <= (bus.bit_length > PW_L) ? PW_L : bus.bit_length;
            par_q   <= 1'b0;
            dout_q  <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (d_cnt != '0) begin
            state_q <= S_DATA;
            en_q    <= 1'b1;
            if (n_q != '0) begin
              dout_q  <= shreg_q[0];
              par_q   <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end else begin
              dout_q <= par_q;   // parity of zero bits
            end
          end else begin
            state_q <= S_STOP;
            dout_q  <= LINE_IDLE;
            done_q  <= (STOP_LIM == '0);
          end
        end
        S_DATA: begin
          if (ctr_tc) begin
            state_q <= S_STOP;
            dout_q  <= LINE_IDLE;
            en_q    <= 1'b0;
            done_q  <= (STOP_LIM == '0);
          end else if (next_idx == n_q) begin
            dout_q <= par_q;     // only reachable when a parity cycle exists
          end else begin
            dout_q  <= shreg_q[0];
            par_q   <= par_q ^ shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end
        end
        S_STOP: begin
          dout_q <= LINE_IDLE;
          if (ctr_tc) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else begin
            done_q <= ctr_tc_next;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ld_ready = (state_q == S_IDLE);
  assign bus.dout     = dout_q;
  assign bus.en_out   = en_q;
  assign bus.done     = done_q;
  assign state_dbg    = STATE_BW'(state_q);
endmodule
